// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: sequencer states, writer
// slot indices and register-file constants.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2,
        IO_WAIT = 2'd3
    } seq_state_t;

    localparam int NUM_WRITERS = 4;
    localparam int REG_W       = 5;
    localparam int WR_OP       = 0;
    localparam int WR_EX       = 1;
    localparam int WR_MEM      = 2;
    localparam int WR_WB       = 3;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // True when any valid in-flight writer targets register r.
    function automatic logic reg_match(
        input logic [REG_W-1:0]             r,
        input logic [NUM_WRITERS-1:0]       wr_valid,
        input logic [NUM_WRITERS*REG_W-1:0] wr_rd
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WRITERS; i++) begin
            if (wr_valid[i] && (wr_rd[i*REG_W +: REG_W] == r))
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_raw_hazard_detect.sv
// raw_hazard_detect: combinational RAW check of the ID source registers
// against the OP/EX/MEM/WB writer vector. Register zero never creates a hazard.
module raw_hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic                         id_valid,
    input  logic [REG_W-1:0]             id_rs,
    input  logic [REG_W-1:0]             id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic [NUM_WRITERS-1:0]       wr_valid,
    input  logic [NUM_WRITERS*REG_W-1:0] wr_rd,
    output logic                         hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs != REG_ZERO) && reg_match(id_rs, wr_valid, wr_rd);
    assign rt_hit = id_uses_rt && (id_rt != REG_ZERO) && reg_match(id_rt, wr_valid, wr_rd);
    assign hazard = id_valid && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush/issue controller for the six-stage core.
// Optional perf counters enabled by defining PIPELINE_SEQUENCER_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for run_start after program load, pipe inactive
// RUN     | normal issue; hazards and output waits stall in place
// FLUSH   | single cycle after a taken branch, IF fetches the target
// IO_WAIT | WB blocked on UART receive, whole pipe frozen
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 5
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         run_start,
    input  logic                         load_busy,
    input  logic                         id_valid,
    input  logic [REG_W-1:0]             id_rs,
    input  logic [REG_W-1:0]             id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic [NUM_WRITERS-1:0]       wr_valid,
    input  logic [NUM_WRITERS*REG_W-1:0] wr_rd,
    input  logic                         branch_taken,
    input  logic [INST_MEM_WIDTH-1:0]    branch_pc,
    input  logic                         uart_in_wait,
    input  logic                         uart_out_wait,
    input  logic                         halt,
    output logic                         fetch_en,
    output logic                         id_hold,
    output logic                         op_bubble,
    output logic                         flush,
    output logic                         freeze,
    output logic [INST_MEM_WIDTH-1:0]    redirect_pc,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   state,
    output logic [31:0]                  cycle_count,
    output logic [31:0]                  stall_count
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       hazard;

    raw_hazard_detect u_hazard (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .wr_valid   (wr_valid),
        .wr_rd      (wr_rd),
        .hazard     (hazard)
    );

    always_ff @(posedge CLK) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        fetch_en    = 1'b0;
        id_hold     = 1'b0;
        op_bubble   = 1'b0;
        flush       = 1'b0;
        freeze      = 1'b0;
        done        = 1'b0;
        redirect_pc = '0;
        case (state_q)
            IDLE: begin
                if (run_start && !load_busy)
                    state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    done    = 1'b1;
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (uart_in_wait) begin
                    freeze  = 1'b1;
                    state_d = IO_WAIT;
                end else if (branch_taken) begin
                    flush       = 1'b1;
                    redirect_pc = branch_pc;
                    state_d     = FLUSH;
                end else if (hazard) begin
                    id_hold   = 1'b1;
                    op_bubble = 1'b1;
                end else if (uart_out_wait) begin
                    freeze = 1'b1;
                end else begin
                    fetch_en = 1'b1;
                end
            end
            FLUSH: begin
                fetch_en = 1'b1;
                state_d  = RUN;
            end
            IO_WAIT: begin
                if (uart_in_wait) begin
                    freeze = 1'b1;
                end else begin
                    fetch_en = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;

`ifdef PIPELINE_SEQUENCER_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] stall_q;

    // A new run starts its counts from zero; counts freeze while idle.
    always_ff @(posedge CLK) begin
        if (reset || (state_q == IDLE && state_d == RUN)) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else if (busy) begin
            cycle_q <= cycle_q + 32'd1;
            if (!fetch_en)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
    assign stall_count = stall_q;
`else
    assign cycle_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed vectors push expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_pipeline_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        run_start, load_busy, id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt;
    logic [3:0]  wr_valid;
    logic [19:0] wr_rd;
    logic        branch_taken, uart_in_wait, uart_out_wait, halt;
    logic [4:0]  branch_pc;
    logic        fetch_en, id_hold, op_bubble, flush, freeze, busy, done;
    logic [4:0]  redirect_pc;
    logic [1:0]  state;
    logic [31:0] cycle_count, stall_count;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(.INST_MEM_WIDTH(5)) dut (
        .CLK(CLK), .reset(reset), .run_start(run_start), .load_busy(load_busy),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .wr_valid(wr_valid), .wr_rd(wr_rd),
        .branch_taken(branch_taken), .branch_pc(branch_pc),
        .uart_in_wait(uart_in_wait), .uart_out_wait(uart_out_wait), .halt(halt),
        .fetch_en(fetch_en), .id_hold(id_hold), .op_bubble(op_bubble),
        .flush(flush), .freeze(freeze), .redirect_pc(redirect_pc),
        .busy(busy), .done(done), .state(state),
        .cycle_count(cycle_count), .stall_count(stall_count)
    );

`ifdef PIPELINE_SEQUENCER_PERF_EN
    localparam logic [31:0] RUN2_CYC   = 32'd20;
    localparam logic [31:0] RUN2_STALL = 32'd3;
`else
    localparam logic [31:0] RUN2_CYC   = 32'd0;
    localparam logic [31:0] RUN2_STALL = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [13:0] ctl;
        bit          chk_cnt;
        logic [31:0] cyc;
        logic [31:0] stl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ctl packing: {state, fetch_en, id_hold, op_bubble, flush, freeze, busy, done, redirect_pc}
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [13:0] act;
            e   = sb.pop_front();
            act = {state, fetch_en, id_hold, op_bubble, flush, freeze, busy, done, redirect_pc};
            n_checks++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL %s: ctl got %b, expected %b", e.name, act, e.ctl);
            end
            if (e.chk_cnt) begin
                n_checks++;
                if (cycle_count !== e.cyc || stall_count !== e.stl) begin
                    n_fail++;
                    $display("FAIL %s_cnt: cycle/stall got %0d/%0d, expected %0d/%0d",
                             e.name, cycle_count, stall_count, e.cyc, e.stl);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string n, input logic [1:0] st, input bit fe, input bit hold,
                        input bit bub, input bit fl, input bit frz, input bit dn,
                        input logic [4:0] rpc, input bit chk, input logic [31:0] c,
                        input logic [31:0] s);
        exp_t e;
        e.name    = n;
        e.ctl     = {st, fe, hold, bub, fl, frz, (st != 2'd0), dn, rpc};
        e.chk_cnt = chk;
        e.cyc     = c;
        e.stl     = s;
        sb.push_back(e);
        cyc();
    endtask

    task automatic ex(input string n, input logic [1:0] st, input bit fe, input bit hold,
                      input bit bub, input bit fl, input bit frz, input bit dn,
                      input logic [4:0] rpc);
        push(n, st, fe, hold, bub, fl, frz, dn, rpc, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic clear_in();
        run_start = 0; load_busy = 0; id_valid = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0; wr_valid = 0; wr_rd = 0; branch_taken = 0;
        branch_pc = 0; uart_in_wait = 0; uart_out_wait = 0; halt = 0;
    endtask

    // ID reads r3 via rs while EX writes r3.
    task automatic set_haz();
        id_valid = 1; id_rs = 5'd3; id_uses_rs = 1;
        wr_valid = 4'b0010; wr_rd = 20'd0; wr_rd[9:5] = 5'd3;
    endtask

    initial begin
        clear_in();
        reset = 1;
        cyc();
        push("reset", 2'd0, 0,0,0,0,0,0, 5'd0, 1'b1, 32'd0, 32'd0);
        reset = 0;

        // start blocked by load, then accepted
        load_busy = 1; run_start = 1;
        ex("start_loadbusy", 2'd0, 0,0,0,0,0,0, 5'd0);
        run_start = 0;
        ex("no_latch", 2'd0, 0,0,0,0,0,0, 5'd0);
        load_busy = 0;
        ex("idle_quiet", 2'd0, 0,0,0,0,0,0, 5'd0);
        run_start = 1;
        ex("start_ok", 2'd0, 0,0,0,0,0,0, 5'd0);
        ex("run_restart_ign", 2'd1, 1,0,0,0,0,0, 5'd0);
        run_start = 0;

        set_haz();
        ex("haz_ex_rs", 2'd1, 0,1,1,0,0,0, 5'd0);
        id_rs = 5'd0;
        ex("haz_r0", 2'd1, 1,0,0,0,0,0, 5'd0);
        id_rt = 5'd7; id_uses_rt = 1; wr_valid = 4'b1000; wr_rd[19:15] = 5'd7;
        ex("haz_wb_rt", 2'd1, 0,1,1,0,0,0, 5'd0);
        id_uses_rt = 0;
        ex("haz_rt_unused", 2'd1, 1,0,0,0,0,0, 5'd0);
        id_uses_rt = 1; id_valid = 0;
        ex("haz_id_invalid", 2'd1, 1,0,0,0,0,0, 5'd0);
        clear_in();
        id_valid = 1; id_rs = 5'd12; id_uses_rs = 1; wr_valid = 4'b0001; wr_rd[4:0] = 5'd12;
        ex("haz_op_rs", 2'd1, 0,1,1,0,0,0, 5'd0);
        wr_valid = 4'b0100;
        ex("haz_wrong_slot", 2'd1, 1,0,0,0,0,0, 5'd0);
        clear_in();
        set_haz(); uart_out_wait = 1;
        ex("haz_over_uout", 2'd1, 0,1,1,0,0,0, 5'd0);
        clear_in(); uart_out_wait = 1;
        ex("uart_out", 2'd1, 0,0,0,0,1,0, 5'd0);
        clear_in();

        branch_taken = 1; branch_pc = 5'd17;
        ex("branch", 2'd1, 0,0,0,1,0,0, 5'd17);
        clear_in(); set_haz();
        ex("flush_state", 2'd2, 1,0,0,0,0,0, 5'd0);
        clear_in();
        ex("after_flush", 2'd1, 1,0,0,0,0,0, 5'd0);

        uart_in_wait = 1; set_haz();
        ex("uin_enter", 2'd1, 0,0,0,0,1,0, 5'd0);
        for (int i = 0; i < 9; i++)
            ex("uin_wait", 2'd3, 0,0,0,0,1,0, 5'd0);
        clear_in();
        ex("uin_release", 2'd3, 1,0,0,0,0,0, 5'd0);
        ex("uin_back_run", 2'd1, 1,0,0,0,0,0, 5'd0);

        halt = 1; branch_taken = 1; branch_pc = 5'd9;
        ex("halt_branch", 2'd1, 0,0,0,1,0,1, 5'd0);
        clear_in();
        ex("halt_idle", 2'd0, 0,0,0,0,0,0, 5'd0);

        // second run: 17 fetch + 2 hazard + halt = 20 busy, 3 stalled
        run_start = 1;
        ex("run2_start", 2'd0, 0,0,0,0,0,0, 5'd0);
        run_start = 0;
        push("run2_first", 2'd1, 1,0,0,0,0,0, 5'd0, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++)
            ex("run2_fetch", 2'd1, 1,0,0,0,0,0, 5'd0);
        set_haz();
        ex("run2_haz", 2'd1, 0,1,1,0,0,0, 5'd0);
        ex("run2_haz", 2'd1, 0,1,1,0,0,0, 5'd0);
        clear_in(); halt = 1;
        ex("run2_halt", 2'd1, 0,0,0,1,0,1, 5'd0);
        clear_in();
        push("run2_perf", 2'd0, 0,0,0,0,0,0, 5'd0, 1'b1, RUN2_CYC, RUN2_STALL);

        // third run: reset while frozen in IO_WAIT
        run_start = 1;
        ex("run3_start", 2'd0, 0,0,0,0,0,0, 5'd0);
        run_start = 0; uart_in_wait = 1;
        ex("run3_uin", 2'd1, 0,0,0,0,1,0, 5'd0);
        ex("run3_iowait", 2'd3, 0,0,0,0,1,0, 5'd0);
        reset = 1;
        ex("run3_rst_cycle", 2'd3, 0,0,0,0,1,0, 5'd0);
        reset = 0;
        push("run3_after_rst", 2'd0, 0,0,0,0,0,0, 5'd0, 1'b1, 32'd0, 32'd0);
        ex("run3_idle", 2'd0, 0,0,0,0,0,0, 5'd0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            cyc();
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
